// File: rtl/core_pkg.sv
// core_pkg: shared core widths, the fetch buffer entry type and the NOP encoding
package core_pkg;
  localparam int DATA_WIDTH = 32;
  localparam int INST_MEM_ADDR_WIDTH = 16;
  localparam logic [DATA_WIDTH-1:0] NOP_INST = 32'h0000_0013;
  typedef struct packed {
    logic [31:0] pc;
    logic [DATA_WIDTH-1:0] inst;
    logic err;
  } if_entry_t;
endpackage

// File: rtl/if_fetch_fifo.sv
// if_fetch_fifo: fetch buffer with sync clear, push/pop and a combinational head
module if_fetch_fifo #(
  parameter int DEPTH = 4,
  parameter type T = logic,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        push,
  input  logic        pop,
  input  T            din,
  output T            head,
  output logic [AW:0] count
);
  T mem_q [DEPTH];
  T mem_d [DEPTH];
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [AW:0] cnt_q, cnt_d;
  // clear drops all entries but still lets a same-cycle push land as the only entry
  always_comb begin
    mem_d = mem_q;
    wp_d = clr ? '0 : wp_q;
    rp_d = clr ? '0 : rp_q + AW'(pop);
    cnt_d = clr ? '0 : cnt_q - (AW+1)'(pop);
    if (push) begin
      mem_d[wp_d] = din;
      wp_d = wp_d + AW'(1);
    end
    cnt_d = cnt_d + (AW+1)'(push);
  end
  // pointers and count reset; storage needs no reset since count gates validity
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (rst) begin
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
      cnt_q <= cnt_d;
    end
  end
  assign head = mem_q[rp_q];
  assign count = cnt_q;
endmodule

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: credit-based sequential fetch with redirect flush; IF_MISALIGN_CHECK_EN enables misaligned-target traps
module if_fetch_unit
  import core_pkg::*;
#(
  parameter int PC_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
  parameter int FIFO_DEPTH = 4,
  parameter int INST_MEM_ADDR_WIDTH = core_pkg::INST_MEM_ADDR_WIDTH
) (
  input  logic                           clk,
  input  logic                           rst,
  output logic                           imem_req_o,
  output logic [INST_MEM_ADDR_WIDTH-1:0] imem_addr_o,
  input  logic [DATA_WIDTH-1:0]          imem_rdata_i,
  input  logic                           redirect_i,
  input  logic [PC_WIDTH-1:0]            redirect_pc_i,
  output logic                           if_valid_o,
  input  logic                           if_ready_i,
  output logic [DATA_WIDTH-1:0]          inst_o,
  output logic [PC_WIDTH-1:0]            pc_o,
  output logic                           fetch_err_o
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  logic [PC_WIDTH-1:0] pc_q, pc_d, req_pc_q, req_pc_d, fetch_pc, tgt;
  logic inflight_q, inflight_d;
  logic pop, push, clr, misalign, halted;
  logic [CW-1:0] count;
  logic [CW:0] occ;
  if_entry_t din, head;
`ifdef IF_MISALIGN_CHECK_EN
  logic halt_q, halt_d;
  assign misalign = redirect_i & |redirect_pc_i[1:0];
  assign halted = halt_q;
  assign halt_d = redirect_i ? misalign : halt_q;
  // a misaligned redirect parks fetch until a clean redirect arrives
  always_ff @(posedge clk) halt_q <= rst ? 1'b0 : halt_d;
  assign fetch_err_o = head.err;
`else
  logic unused_err;
  assign misalign = 1'b0;
  assign halted = 1'b0;
  assign unused_err = head.err;
  assign fetch_err_o = 1'b0;
`endif
  // credit check counts buffered plus in-flight slots, freeing the slot popped this cycle
  always_comb begin
    pop = if_valid_o & if_ready_i;
    occ = (CW+1)'(count) + (CW+1)'(inflight_q) - (CW+1)'(pop);
    tgt = redirect_pc_i & ~PC_WIDTH'(3);
    imem_req_o = ~rst & (redirect_i ? ~misalign : (~halted & (occ < (CW+1)'(FIFO_DEPTH))));
    fetch_pc = redirect_i ? tgt : pc_q;
    imem_addr_o = fetch_pc[INST_MEM_ADDR_WIDTH+1:2];
    pc_d = imem_req_o ? fetch_pc + PC_WIDTH'(4) : pc_q;
    req_pc_d = imem_req_o ? fetch_pc : req_pc_q;
    inflight_d = imem_req_o;
    clr = redirect_i;
    push = misalign | (inflight_q & ~redirect_i);
    din = misalign ? if_entry_t'{pc: 32'(redirect_pc_i), inst: NOP_INST, err: 1'b1}
                   : if_entry_t'{pc: 32'(req_pc_q), inst: imem_rdata_i, err: 1'b0};
  end
  // PC, the PC of the outstanding read, and the in-flight flag
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
      req_pc_q <= RESET_PC;
      inflight_q <= 1'b0;
    end else begin
      pc_q <= pc_d;
      req_pc_q <= req_pc_d;
      inflight_q <= inflight_d;
    end
  end
  if_fetch_fifo #(.DEPTH(FIFO_DEPTH), .T(if_entry_t)) u_fifo (
    .clk(clk),
    .rst(rst),
    .clr(clr),
    .push(push),
    .pop(pop),
    .din(din),
    .head(head),
    .count(count)
  );
  assign if_valid_o = count != '0;
  assign inst_o = head.inst;
  assign pc_o = PC_WIDTH'(head.pc);
endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Parametrised instruction-fetch stage that generates sequential PCs, issues word reads to a synchronous instruction memory and buffers the returned instructions in a small FIFO. It presents instructions to decode through a valid/ready handshake. It accepts a redirect (branch/jump/trap target) that flushes all buffered and in-flight fetches. It sits between the instruction memory and the ID stage, as the successor of the fixed PC+4, single-entry fetch path.

## Interface
- `PC_WIDTH`, default 32: program counter width.
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset; must be word aligned.
- `FIFO_DEPTH`, default 4: fetch buffer entries; a power of two, ≥ 2.
- `INST_MEM_ADDR_WIDTH`, default from `core_pkg`: word-address width of the instruction memory.
- `clk` input 1: clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `imem_req_o` output 1: read request this cycle.
- `imem_addr_o` output INST_MEM_ADDR_WIDTH: word address, equal to PC[INST_MEM_ADDR_WIDTH+1:2].
- `imem_rdata_i` input DATA_WIDTH: read data, valid exactly 1 cycle after `imem_req_o`.
- `redirect_i` input 1: load a new PC and flush.
- `redirect_pc_i` input PC_WIDTH: redirect target.
- `if_valid_o` output 1: FIFO head is valid.
- `if_ready_i` input 1: decode accepts the head.
- `inst_o` output DATA_WIDTH: head instruction.
- `pc_o` output PC_WIDTH: head PC.
- `fetch_err_o` output 1: head carries a misaligned-fetch error. It is tied 0 when the feature is compiled out.

## Operation
- State:
  - `pc_q`: next address to request.
  - `inflight_q`: a request was issued last cycle.
  - FIFO of {pc, inst, err}, with `count`.
- `pop` = `if_valid_o & if_ready_i`.
- Issue condition (no redirect): `count + inflight_q - pop < FIFO_DEPTH`, and not halted.
  - When it holds, `imem_req_o` = 1, `imem_addr_o` is taken from `pc_q`, and `pc_q <= pc_q + 4`.
  - `imem_req_o` is combinational on `if_ready_i`; this is deliberate, to give full throughput.
- Response: when `inflight_q` = 1, push {PC of that request, `imem_rdata_i`, 0}. A registered copy of the request PC is kept for this.
  - The credit rule guarantees the push never finds the FIFO full.
- Redirect (cycle N) has priority over everything else:
  - The FIFO is cleared.
  - The response arriving in N is discarded.
  - `imem_req_o` = 1 with address from `redirect_pc_i`, and `pc_q <= redirect_pc_i + 4`.
  - Any pop in cycle N is still a legal handshake on the old head.
- PC arithmetic wraps modulo 2^PC_WIDTH.
- Simultaneous push and pop: `count` is unchanged.
- FIFO empty: `if_valid_o` = 0; `inst_o`, `pc_o` and `fetch_err_o` are don't-care.

## Timing
- Reset values:
  - `pc_q` = RESET_PC, FIFO empty, `inflight_q` = 0.
  - `if_valid_o` = 0, `imem_req_o` = 0 during reset, `fetch_err_o` = 0.
- First request is in the first cycle with `rst` = 0. The head is valid 2 cycles later.
- Request-to-valid latency is 2 cycles: read in C, push at the end of C+1, visible in C+2.
- Redirect-to-valid latency is 2 cycles.
- Sustained throughput is 1 instruction/cycle while `if_ready_i` is held high.
- Backpressure with `if_ready_i` = 0:
  - The FIFO fills to FIFO_DEPTH, then requests stop.
  - Head outputs are stable while `if_valid_o & ~if_ready_i`.
- Reset asserted mid-operation: all in-flight data is dropped, and fetching restarts from RESET_PC.

## Configuration
- Macro: `IF_MISALIGN_CHECK_EN`.
- Defined: a redirect with `redirect_pc_i[1:0] != 0` does the following.
  - Flushes, and issues no request.
  - Pushes one entry {`redirect_pc_i`, NOP 32'h0000_0013, err = 1}.
  - Halts fetching until the next redirect.
- Undefined:
  - Low two bits of the target are ignored; fetch proceeds from `redirect_pc_i & ~3`.
  - `fetch_err_o` is constant 0.

## Structure
- `core_pkg` gains:
  - constant `NOP_INST` = 32'h0000_0013;
  - typedef `if_entry_t` {pc, inst, err};
  - existing `DATA_WIDTH` and `INST_MEM_ADDR_WIDTH`.
- Sub-module `if_fetch_fifo`:
  - parametrised by depth and entry type;
  - synchronous clear input, push/pop, `count` output;
  - head is read combinationally.
- `if_fetch_unit` holds the PC, credit logic, redirect and misalign handling.

## Test plan
- Reset, RESET_PC = 0x100, `if_ready_i` = 1, memory returns the address as data → heads with PCs 0x100, 0x104, 0x108 appear on consecutive cycles, first valid 2 cycles after reset release.
- Backpressure: `if_ready_i` = 0 for 10 cycles, FIFO_DEPTH = 4 → exactly 4 requests issued, head held at 0x100; release → 0x100..0x10C delivered back to back, with no gap and no duplicate.
- Redirect to 0x200 while 3 entries are buffered and 1 read is in flight → no stale PC is ever presented; next valid head is 0x200, 2 cycles after the redirect.
- Redirect in the same cycle as a pop → the pop completes on the old head; the next head is the target.
- With `IF_MISALIGN_CHECK_EN`: redirect to 0x302 → single head {pc 0x302, inst 0x13, `fetch_err_o` = 1}, no `imem_req_o` until a redirect to 0x400, which resumes normal fetching.
- PC wrap: RESET_PC = 0xFFFF_FFF8 → PCs 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
